hazard_stall_ctrl: RTL and testbench

//  Stall/bubble scheduler for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).

---
 rtl/hazard_stall_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble scheduler for a 5-stage MIPS pipeline: Tuse/Tnew register hazards against
// shadow EX/MEM destination tracking, plus the mult/div busy counter.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic [4:0]       d_wa,
  input  logic [1:0]       d_tnew,
  input  logic             d_md_start,
  input  logic             d_md_div,
  input  logic             d_md_use,
  output logic             stall,
  output logic             md_busy,
  output logic [4:0]       e_wa,
  output logic [1:0]       e_tnew,
  output logic [4:0]       m_wa,
  output logic [1:0]       m_tnew
);

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       e_wa_q, m_wa_q;
  logic [1:0]       e_tnew_q, m_tnew_q;
  logic             hz_rs, hz_rt, hz_md;
  logic             md_load;

  assign e_wa    = e_wa_q;
  assign e_tnew  = e_tnew_q;
  assign m_wa    = m_wa_q;
  assign m_tnew  = m_tnew_q;
  assign md_busy = (cnt_q != '0);

  // Both pipeline stages are ORed; EX-over-MEM priority only matters to the forwarding muxes.
  always_comb begin
    hz_rs = 1'b0;
    hz_rt = 1'b0;
    if (d_rs != 5'd0 && d_tuse_rs != 2'd3) begin
      hz_rs = (e_wa_q == d_rs && e_tnew_q > d_tuse_rs) ||
              (m_wa_q == d_rs && m_tnew_q > d_tuse_rs);
    end
    if (d_rt != 5'd0 && d_tuse_rt != 2'd3) begin
      hz_rt = (e_wa_q == d_rt && e_tnew_q > d_tuse_rt) ||
              (m_wa_q == d_rt && m_tnew_q > d_tuse_rt);
    end
    hz_md = (d_md_start || d_md_use) && md_busy;
    stall = hz_rs || hz_rt || hz_md;
  end

  assign md_load = d_md_start && !stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (md_load) begin
          cnt_d = d_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          if (cnt_d != '0) begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_d == '0) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A stalled ID instruction enters EX as a bubble with no destination.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_wa_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      m_wa_q   <= 5'd0;
      m_tnew_q <= 2'd0;
    end else begin
      e_wa_q   <= stall ? 5'd0 : d_wa;
      e_tnew_q <= stall ? 2'd0 : d_tnew;
      m_wa_q   <= e_wa_q;
      m_tnew_q <= (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed vector table, hand-written MDU/reset
// sequences and a randomized run against an in-flight-instruction reference model.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [4:0] e_wa, m_wa;
  logic [1:0] e_tnew, m_tnew;

  int n_vec = 0;
  int n_bad = 0;

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs),
    .d_tuse_rt(d_tuse_rt), .d_wa(d_wa), .d_tnew(d_tnew), .d_md_start(d_md_start),
    .d_md_div(d_md_div), .d_md_use(d_md_use), .stall(stall), .md_busy(md_busy),
    .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tur, tut;
    logic [4:0] wa;
    logic [1:0] tn;
    logic       ms, mdv, mu;
    logic       x_stall, x_busy;
    logic [4:0] x_ewa, x_mwa;
  } vec_t;

  typedef struct {
    logic [4:0] wa;
    int         tnew;
  } slot_t;

  vec_t  tbl[19];
  slot_t hist[$];
  int    now, md_done;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tur,
                       input logic [1:0] tut, input logic [4:0] wa, input logic [1:0] tn,
                       input logic ms, input logic mdv, input logic mu);
    d_rs = rs; d_rt = rt; d_tuse_rs = tur; d_tuse_rt = tut; d_wa = wa; d_tnew = tn;
    d_md_start = ms; d_md_div = mdv; d_md_use = mu;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(input int rs, input int rt, input int tur, input int tut,
                              input int wa, input int tn, input int ms, input int mdv,
                              input int mu, input int xs, input int xb, input int xe,
                              input int xm);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.tur = 2'(tur); v.tut = 2'(tut); v.wa = 5'(wa);
    v.tn = 2'(tn); v.ms = 1'(ms); v.mdv = 1'(mdv); v.mu = 1'(mu);
    v.x_stall = 1'(xs); v.x_busy = 1'(xb); v.x_ewa = 5'(xe); v.x_mwa = 5'(xm);
    return v;
  endfunction

  // Reference: an instruction issued k cycles ago still needs max(0, tnew-(k-1)) cycles.
  function automatic int remaining(input int age);
    int r;
    r = hist[age].tnew - age;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit src_hz(input logic [4:0] s, input logic [1:0] tuse);
    if (s == 5'd0 || tuse == 2'd3) return 1'b0;
    for (int a = 0; a < hist.size() && a < 2; a++) begin
      if (hist[a].wa == s && remaining(a) > int'(tuse)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_busy();
    return now < md_done;
  endfunction

  function automatic bit model_stall();
    return src_hz(d_rs, d_tuse_rs) || src_hz(d_rt, d_tuse_rt) ||
           ((d_md_start || d_md_use) && model_busy());
  endfunction

  task automatic model_advance();
    slot_t s;
    bit    st;
    st = model_stall();
    s.wa   = st ? 5'd0 : d_wa;
    s.tnew = st ? 0 : int'(d_tnew);
    if (d_md_start && !st) md_done = now + 1 + (d_md_div ? 10 : 5);
    hist.push_front(s);
    if (hist.size() > 2) void'(hist.pop_back());
    now++;
  endtask

  task automatic model_clear();
    hist.delete();
    now = 0;
    md_done = 0;
  endtask

  initial begin
    // Directed table: one ID instruction per cycle, expectations sampled before the edge.
    tbl[0]  = mk(0, 0, 3, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0);  // lw $1
    tbl[1]  = mk(1, 0, 1, 3, 4, 1, 0, 0, 0, 1, 0, 1, 0);  // addu rs=$1 stalls
    tbl[2]  = mk(1, 0, 1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 1);  // released, bubble in EX
    tbl[3]  = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    tbl[4]  = mk(0, 0, 3, 3, 1, 2, 0, 0, 0, 0, 0, 0, 4);  // lw $1
    tbl[5]  = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 1, 0);  // beq: two-cycle stall
    tbl[6]  = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[7]  = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0);  // addu $1
    tbl[9]  = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 1, 0);  // beq: one-cycle stall
    tbl[10] = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 3, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0);  // lw $0
    tbl[12] = mk(0, 0, 1, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0);  // addu rs=$0 -> $2
    tbl[13] = mk(0, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2, 0);  // sw rt=$2 tuse=2
    tbl[14] = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[15] = mk(0, 0, 3, 3, 3, 2, 0, 0, 0, 0, 0, 0, 0);  // lw $3
    tbl[16] = mk(3, 3, 1, 3, 5, 1, 0, 0, 0, 1, 0, 3, 0);  // addu rs=$3, rt unused
    tbl[17] = mk(3, 3, 1, 3, 5, 1, 0, 0, 0, 0, 0, 0, 3);
    tbl[18] = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 5, 0);

    reset = 1'b1;
    nop();
    #12;
    check("reset_stall", int'(stall), 0);
    check("reset_md_busy", int'(md_busy), 0);
    check("reset_e_wa", int'(e_wa), 0);
    check("reset_m_wa", int'(m_wa), 0);
    check("reset_tnew", int'({e_tnew, m_tnew}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].tur, tbl[i].tut, tbl[i].wa, tbl[i].tn,
            tbl[i].ms, tbl[i].mdv, tbl[i].mu);
      @(negedge clk);
      check($sformatf("tbl%0d_stall", i), int'(stall), int'(tbl[i].x_stall));
      check($sformatf("tbl%0d_md_busy", i), int'(md_busy), int'(tbl[i].x_busy));
      check($sformatf("tbl%0d_e_wa", i), int'(e_wa), int'(tbl[i].x_ewa));
      check($sformatf("tbl%0d_m_wa", i), int'(m_wa), int'(tbl[i].x_mwa));
      @(posedge clk); #1;
    end

    // mult then mflo (5 busy cycles), div then mfhi (10 busy cycles).
    for (int k = 0; k < 2; k++) begin
      int n;
      n = (k == 0) ? 5 : 10;
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'(k), 1'b0);
      @(negedge clk);
      check("md_issue_stall", int'(stall), 0);
      @(posedge clk); #1;
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        check($sformatf("md%0d_busy_c%0d", k, c), int'(md_busy), 1);
        check($sformatf("md%0d_stall_c%0d", k, c), int'(stall), 1);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check($sformatf("md%0d_release_busy", k), int'(md_busy), 0);
      check($sformatf("md%0d_release_stall", k), int'(stall), 0);
      @(posedge clk); #1;
    end

    // div in flight, reset pulsed between edges while cnt=7.
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    for (int w = 6; w <= 8; w++) begin
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'(w), 2'd1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("rst_pre_stall", int'(stall), 1);
    check("rst_pre_busy", int'(md_busy), 1);
    check("rst_pre_e_wa", int'(e_wa), 8);
    check("rst_pre_m_wa", int'(m_wa), 7);
    #2 reset = 1'b1;
    #1;
    check("rst_async_stall", int'(stall), 0);
    check("rst_async_busy", int'(md_busy), 0);
    check("rst_async_e_wa", int'(e_wa), 0);
    check("rst_async_m_wa", int'(m_wa), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    nop();
    @(negedge clk);
    check("rst_after_busy", int'(md_busy), 0);
    @(posedge clk); #1;

    // Randomized run against the reference model.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_clear();
    for (int cyc = 0; cyc < 600; cyc++) begin
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      d_tuse_rs  = 2'($urandom_range(0, 3));
      d_tuse_rt  = 2'($urandom_range(0, 3));
      d_wa       = 5'($urandom_range(0, 3));
      d_tnew     = 2'($urandom_range(0, 3));
      d_md_start = ($urandom_range(0, 9) == 0);
      d_md_div   = 1'($urandom_range(0, 1));
      d_md_use   = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      check("rnd_stall", int'(stall), int'(model_stall()));
      check("rnd_md_busy", int'(md_busy), int'(model_busy()));
      check("rnd_e_wa", int'(e_wa), (hist.size() > 0) ? int'(hist[0].wa) : 0);
      check("rnd_e_tnew", int'(e_tnew), (hist.size() > 0) ? hist[0].tnew : 0);
      check("rnd_m_wa", int'(m_wa), (hist.size() > 1) ? int'(hist[1].wa) : 0);
      check("rnd_m_tnew", int'(m_tnew), (hist.size() > 1) ? remaining(1) : 0);
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_clear();
      end
      model_advance();
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
